// File: rtl/float16_pkg.sv
// float16_pkg -- shared definitions for the binary16 adder.
// Contents: field widths, bias/limit constants, canonical special encodings,
// the binary16 bit-field struct, the operand-class enum and a classifier.
package float16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBNORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  function automatic fp_class_t fp16_classify(input fp16_t v);
    if (v.exp == '0) return (v.frac == '0) ? CLS_ZERO : CLS_SUBNORM;
    if (v.exp == '1) return (v.frac == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/float16_lzc.sv
// float16_lzc -- combinational leading-zero counter over a 14-bit significand.
// Ports:
//   value  in   14  significand, bit 13 is the hidden-bit position
//   count  out  4   number of leading zeros (14 when value is all zero)
module float16_lzc (
  input  logic [13:0] value,
  output logic [3:0]  count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (value[i]) count = 4'(13 - i);
    end
  end

endmodule

// File: rtl/float16_adder.sv
// float16_adder -- 5-stage pipelined IEEE-754 binary16 adder, round to
// nearest even, one operand pair per clock, no backpressure.
// Ports:
//   clk         in   1   rising-edge clock
//   rst_b       in   1   synchronous active-low reset
//   de_in       in   1   operands valid
//   data_in_01  in   16  operand A
//   data_in_02  in   16  operand B
//   de_out      out  1   result valid, de_in delayed by 5 clocks
//   data_out    out  16  A+B, holds its last value while de_out=0
// Build option: FLOAT16_ADD_SUBNORM_EN enables gradual underflow (subnormal
// inputs and outputs); without it subnormals flush to signed zero.
module float16_adder
  import float16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        de_in,
  input  logic [15:0] data_in_01,
  input  logic [15:0] data_in_02,
  output logic        de_out,
  output logic [15:0] data_out
);

  function automatic logic [4:0] eff_exp(input logic [4:0] e);
    return (e == 5'd0) ? 5'd1 : e;
  endfunction

  logic s1_vld, s2_vld, s3_vld, s4_vld;

  // ---------------- stage 1: unpack, classify, swap ----------------
  fp16_t      op_a, op_b;
  fp_class_t  cls_a, cls_b;
  logic       a_zero, b_zero, a_ge_b;
  logic       x_sign;
  logic [4:0] x_exp, y_exp;
  logic [9:0] x_frac, y_frac;
  logic       s1_special_d;
  logic [15:0] s1_special_val_d;

  assign op_a  = data_in_01;
  assign op_b  = data_in_02;
  assign cls_a = fp16_classify(op_a);
  assign cls_b = fp16_classify(op_b);

`ifdef FLOAT16_ADD_SUBNORM_EN
  assign a_zero = (cls_a == CLS_ZERO);
  assign b_zero = (cls_b == CLS_ZERO);
`else
  assign a_zero = (cls_a == CLS_ZERO) || (cls_a == CLS_SUBNORM);
  assign b_zero = (cls_b == CLS_ZERO) || (cls_b == CLS_SUBNORM);
`endif

  // NaN/Inf/zero operands never need the arithmetic path; their result is
  // decided here and carried alongside the pipeline.
  always_comb begin
    s1_special_d     = 1'b1;
    s1_special_val_d = QNAN;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN)
      s1_special_val_d = QNAN;
    else if (cls_a == CLS_INF && cls_b == CLS_INF)
      s1_special_val_d = (op_a.sign != op_b.sign) ? QNAN : data_in_01;
    else if (cls_a == CLS_INF)
      s1_special_val_d = data_in_01;
    else if (cls_b == CLS_INF)
      s1_special_val_d = data_in_02;
    else if (a_zero && b_zero)
      s1_special_val_d = {op_a.sign & op_b.sign, 15'h0000};
    else if (b_zero)
      s1_special_val_d = data_in_01;
    else if (a_zero)
      s1_special_val_d = data_in_02;
    else
      s1_special_d = 1'b0;
  end

  // Magnitude order follows the {exp,frac} integer order.
  assign a_ge_b = data_in_01[14:0] >= data_in_02[14:0];
  assign x_sign = a_ge_b ? op_a.sign : op_b.sign;
  assign x_exp  = a_ge_b ? op_a.exp  : op_b.exp;
  assign x_frac = a_ge_b ? op_a.frac : op_b.frac;
  assign y_exp  = a_ge_b ? op_b.exp  : op_a.exp;
  assign y_frac = a_ge_b ? op_b.frac : op_a.frac;

  logic        s1_sign, s1_sub, s1_special;
  logic [4:0]  s1_exp, s1_diff;
  logic [10:0] s1_sig_x, s1_sig_y;
  logic [15:0] s1_special_val;

  // ---------------- stage 2: align ----------------
  logic [3:0]  s2_shift_d;
  logic [27:0] s2_ext_d;
  logic [13:0] s2_small_d;

  assign s2_shift_d = (s1_diff > 5'd14) ? 4'd14 : s1_diff[3:0];
  assign s2_ext_d   = {s1_sig_y, 3'b000, 14'h0000} >> s2_shift_d;
  // Bit 0 becomes the sticky bit: OR of everything shifted past it.
  assign s2_small_d = {s2_ext_d[27:15], s2_ext_d[14] | (|s2_ext_d[13:0])};

  logic        s2_sign, s2_sub, s2_special;
  logic [4:0]  s2_exp;
  logic [13:0] s2_big, s2_small;
  logic [15:0] s2_special_val;

  // ---------------- stage 3: add / subtract ----------------
  logic [14:0] s3_sum_d;
  assign s3_sum_d = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                           : ({1'b0, s2_big} + {1'b0, s2_small});

  logic        s3_sign, s3_special;
  logic [4:0]  s3_exp;
  logic [14:0] s3_sum;
  logic [15:0] s3_special_val;

  // ---------------- stage 4: normalize ----------------
  logic [3:0]  s4_lz;
  logic [5:0]  s4_exp_d;
  logic [13:0] s4_man_d;
  logic        s4_force_d;
  logic [15:0] s4_force_val_d;

  float16_lzc u_lzc (
    .value (s3_sum[13:0]),
    .count (s4_lz)
  );

`ifdef FLOAT16_ADD_SUBNORM_EN
  // Never shift the exponent below 1; a result left without its hidden bit
  // is a subnormal and is packed with exponent field 0 in stage 5.
  logic [4:0] s4_limit, s4_shift;
  assign s4_limit = s3_exp - 5'd1;
  assign s4_shift = ({1'b0, s4_lz} < s4_limit) ? {1'b0, s4_lz} : s4_limit;
`endif

  always_comb begin
    s4_exp_d       = '0;
    s4_man_d       = '0;
    s4_force_d     = s3_special;
    s4_force_val_d = s3_special_val;
    if (!s3_special) begin
      if (s3_sum == '0) begin
        s4_force_d     = 1'b1;
        s4_force_val_d = 16'h0000;
      end else if (s3_sum[14]) begin
        s4_man_d = {s3_sum[14:2], |s3_sum[1:0]};
        s4_exp_d = {1'b0, s3_exp} + 6'd1;
      end else begin
`ifdef FLOAT16_ADD_SUBNORM_EN
        s4_man_d = s3_sum[13:0] << s4_shift;
        s4_exp_d = {1'b0, s3_exp - s4_shift};
`else
        if ({1'b0, s4_lz} >= s3_exp) begin
          s4_force_d     = 1'b1;
          s4_force_val_d = {s3_sign, 15'h0000};
        end else begin
          s4_man_d = s3_sum[13:0] << s4_lz;
          s4_exp_d = {1'b0, s3_exp - {1'b0, s4_lz}};
        end
`endif
      end
    end
  end

  logic        s4_sign, s4_force;
  logic [5:0]  s4_exp;
  logic [13:0] s4_man;
  logic [15:0] s4_force_val;

  // ---------------- stage 5: round, pack ----------------
  logic        s5_round;
  logic [5:0]  s5_field;
  logic [15:0] s5_packed, s5_result;

  assign s5_round  = s4_man[2] & (s4_man[1] | s4_man[0] | s4_man[3]);
  assign s5_field  = s4_man[13] ? s4_exp : 6'd0;
  // A rounding carry out of the fraction ripples into the exponent field,
  // which renormalizes (and turns a top subnormal into the minimum normal).
  assign s5_packed = {s5_field, s4_man[12:3]} + {15'h0000, s5_round};
  assign s5_result = s4_force ? s4_force_val :
                     (s5_packed[15:10] >= 6'(EXP_MAX)) ? (s4_sign ? NEG_INF : POS_INF) :
                     {s4_sign, s5_packed[14:0]};

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      s4_vld   <= 1'b0;
      de_out   <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      s1_vld <= de_in;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      s4_vld <= s3_vld;
      de_out <= s4_vld;
      if (s4_vld) data_out <= s5_result;
    end
  end

  always_ff @(posedge clk) begin
    s1_sign        <= x_sign;
    s1_sub         <= op_a.sign ^ op_b.sign;
    s1_exp         <= eff_exp(x_exp);
    s1_diff        <= eff_exp(x_exp) - eff_exp(y_exp);
    s1_sig_x       <= {x_exp != 5'd0, x_frac};
    s1_sig_y       <= {y_exp != 5'd0, y_frac};
    s1_special     <= s1_special_d;
    s1_special_val <= s1_special_val_d;

    s2_sign        <= s1_sign;
    s2_sub         <= s1_sub;
    s2_exp         <= s1_exp;
    s2_big         <= {s1_sig_x, 3'b000};
    s2_small       <= s2_small_d;
    s2_special     <= s1_special;
    s2_special_val <= s1_special_val;

    s3_sign        <= s2_sign;
    s3_exp         <= s2_exp;
    s3_sum         <= s3_sum_d;
    s3_special     <= s2_special;
    s3_special_val <= s2_special_val;

    s4_sign        <= s3_sign;
    s4_exp         <= s4_exp_d;
    s4_man         <= s4_man_d;
    s4_force       <= s4_force_d;
    s4_force_val   <= s4_force_val_d;
  end

endmodule

// File: tb/tb_float16_adder.sv
// tb_float16_adder -- self-checking bench for float16_adder: directed vector
// table, hand-written reset/latency sequences, and randomized streaming
// checked against a real-arithmetic binary16 reference model.
module tb_float16_adder;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        de_in = 1'b0;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        de_out;
  logic [15:0] data_out;

  always #5 clk = ~clk;

  float16_adder dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .de_in      (de_in),
    .data_in_01 (in_a),
    .data_in_02 (in_b),
    .de_out     (de_out),
    .data_out   (data_out)
  );

  int checks = 0;
  int passes = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
    else m = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic       sgn;
    real        m, sc, fl;
    int         e;
    longint     q;
    logic [4:0] fld;
    sgn = (r < 0.0);
    m = sgn ? -r : r;
`ifndef FLOAT16_ADD_SUBNORM_EN
    if (m < pow2(-14)) return {sgn, 15'h0000};
`endif
    e = 16;
    while (e > -14 && m < pow2(e)) e--;
    sc = m / pow2(e - 10);
    fl = $floor(sc);
    q = longint'(fl);
    if ((sc - fl) > 0.5 || ((sc - fl) == 0.5 && q[0])) q++;
    if (q >= 2048) begin
      q = q / 2;
      e++;
    end
    if (q < 1024) return {sgn, 5'd0, q[9:0]};
    if (e + 15 >= 31) return {sgn, 5'h1F, 10'h000};
    fld = 5'(e + 15);
    return {sgn, fld, q[9:0]};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] aa, bb;
    logic a_nan, b_nan, a_inf, b_inf;
    real r;
    aa = a;
    bb = b;
`ifndef FLOAT16_ADD_SUBNORM_EN
    if (aa[14:10] == 5'd0) aa = {aa[15], 15'h0000};
    if (bb[14:10] == 5'd0) bb = {bb[15], 15'h0000};
`endif
    a_nan = (aa[14:10] == 5'h1F) && (aa[9:0] != 10'd0);
    b_nan = (bb[14:10] == 5'h1F) && (bb[9:0] != 10'd0);
    a_inf = (aa[14:0] == 15'h7C00);
    b_inf = (bb[14:0] == 15'h7C00);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf) return (aa[15] != bb[15]) ? 16'h7E00 : aa;
    if (a_inf) return aa;
    if (b_inf) return bb;
    if (aa[14:0] == 15'd0 && bb[14:0] == 15'd0) return {aa[15] & bb[15], 15'h0000};
    if (bb[14:0] == 15'd0) return aa;
    if (aa[14:0] == 15'd0) return bb;
    r = h2r(aa) + h2r(bb);
    if (r == 0.0) return 16'h0000;
    return r2h(r);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic gen_pair(output logic [15:0] x, output logic [15:0] y);
    case ($urandom_range(0, 4))
      0: begin x = 16'($urandom); y = 16'($urandom); end
      1: begin
        x = 16'($urandom);
        y = {~x[15], x[14:0] ^ 15'($urandom_range(0, 7))};
      end
      2: begin
        x = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
        y = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
      end
      3: begin
        x = 16'($urandom);
        y = {1'($urandom), x[14:10] ^ 5'($urandom_range(0, 3)), 10'($urandom)};
      end
      default: begin
        x = {1'($urandom), 5'($urandom_range(28, 30)), 10'($urandom)};
        y = {1'($urandom), 5'($urandom_range(28, 30)), 10'($urandom)};
      end
    endcase
  endtask

  // One isolated operation: de_out must stay low for four clocks and rise
  // on the fifth, then fall while data_out holds the result.
  task automatic run_single(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] y, input int idx);
    @(posedge clk); #1;
    de_in = 1'b1;
    in_a  = a;
    in_b  = b;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) de_in = 1'b0;
      if (i < 5) check1($sformatf("vec%0d de_out early c%0d", idx, i), de_out, 1'b0);
    end
    check1($sformatf("vec%0d de_out", idx), de_out, 1'b1);
    check16($sformatf("vec%0d %h+%h", idx, a, b), data_out, y);
    @(posedge clk); #1;
    check1($sformatf("vec%0d de_out fall", idx), de_out, 1'b0);
    check16($sformatf("vec%0d hold", idx), data_out, y);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  typedef struct {
    logic        de;
    logic [15:0] a;
    logic [15:0] b;
  } stim_t;

  vec_t  vecs[$];
  stim_t stim[$];

  initial begin
    logic [15:0] last_y;
    logic [15:0] ra, rb;
    int n;

    vecs.push_back('{16'h3C00, 16'h3C00, 16'h4000});
    vecs.push_back('{16'h4000, 16'hB800, 16'h3E00});
    vecs.push_back('{16'h3C00, 16'hBC00, 16'h0000});
    vecs.push_back('{16'h8000, 16'h8000, 16'h8000});
    vecs.push_back('{16'h3C00, 16'h1000, 16'h3C00});
    vecs.push_back('{16'h3C01, 16'h1000, 16'h3C02});
    vecs.push_back('{16'h3BFF, 16'h0C00, 16'h3C00});
    vecs.push_back('{16'h7BFF, 16'h7BFF, 16'h7C00});
    vecs.push_back('{16'h7C00, 16'hFC00, 16'h7E00});
    vecs.push_back('{16'h7E00, 16'h3C00, 16'h7E00});
    vecs.push_back('{16'h7C00, 16'h3C00, 16'h7C00});
    vecs.push_back('{16'hFC00, 16'hFC00, 16'hFC00});
    vecs.push_back('{16'h3C00, 16'h8000, 16'h3C00});
    vecs.push_back('{16'h8000, 16'h0000, 16'h0000});
`ifdef FLOAT16_ADD_SUBNORM_EN
    vecs.push_back('{16'h0001, 16'h0001, 16'h0002});
    vecs.push_back('{16'h0400, 16'h8401, 16'h8001});
    vecs.push_back('{16'h03FF, 16'h0001, 16'h0400});
`else
    vecs.push_back('{16'h0001, 16'h0001, 16'h0000});
    vecs.push_back('{16'h0400, 16'h8401, 16'h8000});
    vecs.push_back('{16'h03FF, 16'h3C00, 16'h3C00});
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check1("reset de_out", de_out, 1'b0);
    check16("reset data_out", data_out, 16'h0000);
    rst_b = 1'b1;

    // Directed table.
    foreach (vecs[i]) run_single(vecs[i].a, vecs[i].b, vecs[i].y, i);
    last_y = vecs[vecs.size() - 1].y;

    // Streaming: 10 back-to-back, gap, 3 more, then a random de pattern.
    for (int i = 0; i < 10; i++) begin gen_pair(ra, rb); stim.push_back('{1'b1, ra, rb}); end
    for (int i = 0; i < 3; i++) stim.push_back('{1'b0, 16'h0000, 16'h0000});
    for (int i = 0; i < 3; i++) begin gen_pair(ra, rb); stim.push_back('{1'b1, ra, rb}); end
    for (int i = 0; i < 1500; i++) begin
      gen_pair(ra, rb);
      stim.push_back('{1'($urandom_range(0, 1)), ra, rb});
    end
    n = stim.size();
    for (int t = 0; t < n + 6; t++) begin
      @(posedge clk); #1;
      if (t >= 5 && stim[t - 5].de) begin
        check1($sformatf("stream de_out t%0d", t), de_out, 1'b1);
        last_y = ref_add(stim[t - 5].a, stim[t - 5].b);
        check16($sformatf("stream %h+%h t%0d", stim[t - 5].a, stim[t - 5].b, t), data_out, last_y);
      end else begin
        check1($sformatf("stream de_out idle t%0d", t), de_out, 1'b0);
        check16($sformatf("stream hold t%0d", t), data_out, last_y);
      end
      if (t < n) begin
        de_in = stim[t].de;
        in_a  = stim[t].a;
        in_b  = stim[t].b;
      end else begin
        de_in = 1'b0;
      end
    end

    // Reset with three operations in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      de_in = 1'b1;
      in_a  = 16'h3C00 + 16'(i);
      in_b  = 16'h4000;
      @(posedge clk); #1;
    end
    de_in = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check1($sformatf("inflight rst de_out c%0d", i), de_out, 1'b0);
      check16($sformatf("inflight rst data_out c%0d", i), data_out, 16'h0000);
    end
    rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check1($sformatf("post rst no pulse c%0d", i), de_out, 1'b0);
      check16($sformatf("post rst data_out c%0d", i), data_out, 16'h0000);
    end

    // Pipeline recovers after reset.
    run_single(16'h3C00, 16'h3C00, 16'h4000, 100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
